// File: rtl/sense_trace_capture.sv
// Trace-capture engine: records decoded sensor samples into an on-chip buffer
// a programmable delay after a trigger edge, with run-time length/decimation.
module sense_trace_capture #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DLY_W  = 16
) (
  input  logic              clk48m,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [3:0]        cfg_decim,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                trig_q;
  logic [DLY_W-1:0]    dly_sh_q, dly_sh_d;
  logic [ADDR_W-1:0]   len_sh_q, len_sh_d;
  logic [3:0]          decim_sh_q, decim_sh_d;
  logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
  logic [3:0]          decim_cnt_q, decim_cnt_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                we_c;
  logic                trig_edge_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign trig_edge_c = trig & ~trig_q;

  // Next-state, shadow config and counter update; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    dly_sh_d    = dly_sh_q;
    len_sh_d    = len_sh_q;
    decim_sh_d  = decim_sh_q;
    dly_cnt_d   = dly_cnt_q;
    decim_cnt_d = decim_cnt_q;
    wr_count_d  = wr_count_q;
    we_c        = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            dly_sh_d    = cfg_delay;
            len_sh_d    = cfg_len;
            decim_sh_d  = cfg_decim;
            wr_count_d  = '0;
            decim_cnt_d = '0;
            state_d     = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_edge_c) begin
            decim_cnt_d = '0;
            if (dly_sh_q == '0) begin
              state_d = S_CAPTURE;
            end else begin
              dly_cnt_d = dly_sh_q;
              state_d   = S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (dly_cnt_q <= DLY_W'(1)) begin
            state_d = S_CAPTURE;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end
        S_CAPTURE: begin
          if (decim_cnt_q == '0) begin
            we_c       = 1'b1;
            wr_count_d = wr_count_q + CNT_W'(1);
            if (wr_count_q == CNT_W'(len_sh_q)) begin
              state_d = S_DONE;
            end
          end
          decim_cnt_d = (decim_cnt_q == decim_sh_q) ? 4'd0 : decim_cnt_q + 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      dly_sh_q    <= '0;
      len_sh_q    <= '0;
      decim_sh_q  <= '0;
      dly_cnt_q   <= '0;
      decim_cnt_q <= '0;
      wr_count_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig;
      dly_sh_q    <= dly_sh_d;
      len_sh_q    <= len_sh_d;
      decim_sh_q  <= decim_sh_d;
      dly_cnt_q   <= dly_cnt_d;
      decim_cnt_q <= decim_cnt_d;
      wr_count_q  <= wr_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Sample buffer write port; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk48m) begin
    if (we_c) begin
      mem_q[wr_count_q[ADDR_W-1:0]] <= sample_in;
    end
  end

  // Registered read-first readback port.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sense_trace_capture.sv
// Randomized bench for sense_trace_capture; expected buffer contents come from
// a per-cycle history of driven samples indexed by the trigger-relative schedule.
module tb_sense_trace_capture;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DLY_W  = 16;
  localparam int unsigned CW     = ADDR_W + 1;
  localparam int          HMASK  = 16383;

  logic              clk48m = 1'b0;
  logic              rst;
  logic              arm;
  logic              abort;
  logic              trig;
  logic [DATA_W-1:0] sample_in;
  logic [DLY_W-1:0]  cfg_delay;
  logic [ADDR_W-1:0] cfg_len;
  logic [3:0]        cfg_decim;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] hist [0:16383];

  sense_trace_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DLY_W(DLY_W)) dut (
    .clk48m(clk48m), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .sample_in(sample_in), .cfg_delay(cfg_delay), .cfg_len(cfg_len),
    .cfg_decim(cfg_decim), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #10 clk48m = ~clk48m;

  // Cycle number of each rising edge and the sample value presented at it.
  always @(posedge clk48m) begin
    cyc = cyc + 1;
    hist[cyc & HMASK] = sample_in;
  end

  task automatic tick();
    @(negedge clk48m);
  endtask

  // Full arm/trigger/capture/readback sequence with the schedule computed
  // from the trigger edge cycle, delay, length and decimation.
  task automatic run_capture(input int dly, input int ln, input int dec,
                             input bit ramp, input bit retrig, input bit rearm);
    int t, first, last, expw;
    logic [DATA_W-1:0] exp_v;
    cfg_delay = DLY_W'(dly);
    cfg_len   = ADDR_W'(ln);
    cfg_decim = 4'(dec);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy: got %0b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arm_done: got %0b expected 0", done); end
    checks++; if (wr_count !== CW'(0)) begin errors++; $display("FAIL arm_wr_count: got %0d expected 0", wr_count); end
    if (rearm) begin
      cfg_delay = DLY_W'(dly + 7);
      cfg_len   = ADDR_W'(ln + 5);
      cfg_decim = 4'(dec + 3);
      arm = 1'b1;
      tick();
      arm = 1'b0;
    end
    cfg_delay = DLY_W'($urandom);
    cfg_len   = ADDR_W'($urandom);
    cfg_decim = 4'($urandom);
    repeat ($urandom_range(1, 3)) tick();
    trig = 1'b1;
    t = cyc + 1;
    first = t + 1 + dly;
    last = first + ln * (dec + 1);
    sample_in = ramp ? 8'h10 : DATA_W'($urandom);
    while (cyc < last) begin
      tick();
      sample_in = ramp ? sample_in + 8'd1 : DATA_W'($urandom);
      if (retrig) begin
        if (cyc == t + 1) trig = 1'b0;
        else if (cyc == t + 2) trig = 1'b1;
      end
      if (cyc < last) begin
        expw = (cyc < first) ? 0 : ((cyc - first) / (dec + 1) + 1);
        checks++;
        if (wr_count !== CW'(expw) || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL capture_progress cyc=%0d: got wr_count=%0d busy=%0b done=%0b expected %0d 1 0",
                   cyc - t, wr_count, busy, done, expw);
        end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_rise: got %0b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %0b expected 0", busy); end
    checks++; if (wr_count !== CW'(ln + 1)) begin errors++; $display("FAIL final_count: got %0d expected %0d", wr_count, ln + 1); end
    trig = 1'b0;
    repeat (3) tick();
    checks++;
    if (done !== 1'b1 || wr_count !== CW'(ln + 1)) begin
      errors++;
      $display("FAIL done_hold: got done=%0b wr_count=%0d expected 1 %0d", done, wr_count, ln + 1);
    end
    for (int k = 0; k <= ln; k++) begin
      rd_addr = ADDR_W'(k);
      tick();
      exp_v = hist[(first + k * (dec + 1)) & HMASK];
      checks++;
      if (rd_data !== exp_v) begin
        errors++;
        $display("FAIL readback addr=%0d: got %0h expected %0h", k, rd_data, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_count !== CW'(0) || rd_data !== DATA_W'(0)) begin
        errors++;
        $display("FAIL reset_hold: got busy=%0b done=%0b wr_count=%0d rd_data=%0h expected all 0",
                 busy, done, wr_count, rd_data);
      end
    end
    rst = 1'b0;
    repeat (100) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_count !== CW'(0)) begin
        errors++;
        $display("FAIL reset_idle: got busy=%0b done=%0b wr_count=%0d expected 0 0 0", busy, done, wr_count);
      end
    end
  endtask

  task automatic test_basic();
    run_capture(0, 3, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_delay_retrig();
    run_capture(5, 1, 2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_arm_while_busy();
    run_capture(3, 2, 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int d;
    repeat (5) begin
      d = $urandom_range(0, 20);
      run_capture(d, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0,
                  (d >= 3) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_full_depth();
    run_capture($urandom_range(0, 4), 511, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    int t;
    logic [DATA_W-1:0] exp_v;
    cfg_delay = '0;
    cfg_len   = ADDR_W'(50);
    cfg_decim = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trig = 1'b1;
    t = cyc + 1;
    sample_in = DATA_W'($urandom);
    while (cyc < t + 10) begin
      tick();
      sample_in = DATA_W'($urandom);
    end
    checks++; if (wr_count !== CW'(10)) begin errors++; $display("FAIL pre_abort_count: got %0d expected 10", wr_count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_count !== CW'(10)) begin
      errors++;
      $display("FAIL abort_idle: got busy=%0b done=%0b wr_count=%0d expected 0 0 10", busy, done, wr_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || wr_count !== CW'(10)) begin
      errors++;
      $display("FAIL abort_stay: got busy=%0b wr_count=%0d expected 0 10", busy, wr_count);
    end
    trig = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd_addr = ADDR_W'(k);
      tick();
      exp_v = hist[(t + 1 + k) & HMASK];
      checks++;
      if (rd_data !== exp_v) begin
        errors++;
        $display("FAIL abort_retain addr=%0d: got %0h expected %0h", k, rd_data, exp_v);
      end
    end
    run_capture(2, 4, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_arm_with_trig();
    cfg_delay = '0;
    cfg_len   = ADDR_W'(3);
    cfg_decim = '0;
    arm  = 1'b1;
    trig = 1'b1;
    tick();
    arm = 1'b0;
    repeat (10) begin
      tick();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || wr_count !== CW'(0)) begin
        errors++;
        $display("FAIL arm_trig_same: got busy=%0b done=%0b wr_count=%0d expected 1 0 0", busy, done, wr_count);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    trig = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_armed: got busy=%0b done=%0b expected 0 0", busy, done); end
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_over_arm: got busy=%0b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; sample_in = '0;
    cfg_delay = '0; cfg_len = '0; cfg_decim = '0; rd_addr = '0;
    test_reset();
    test_basic();
    test_delay_retrig();
    test_arm_while_busy();
    test_random();
    test_full_depth();
    test_abort();
    test_arm_with_trig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
